// File: rtl/bj_table_ctrl.sv
// Blackjack table sequencer: N player seats plus a dealer; deals, plays turns, drives the dealer and settles.
// Optional feature macro BJ_DEALER_H17_EN: when defined the dealer also hits on a soft DEALER_STAND.
module bj_table_ctrl #(
  parameter int N_PLAYERS    = 2,
  parameter int DEALER_STAND = 17,
  parameter int MAX_CARDS    = 8
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       EN,
  input  logic                       START,
  input  logic                       HIT,
  input  logic                       STAND,
  input  logic [3:0]                 CARD,
  input  logic                       CARD_RDY,
  output logic                       CARD_USED,
  output logic                       LD_VALID,
  output logic [2:0]                 LD_HAND,
  output logic [2:0]                 LD_POS,
  output logic [3:0]                 LD_CARD,
  output logic [5*(N_PLAYERS+1)-1:0] SCORE,
  output logic [2:0]                 ACTIVE,
  output logic [2*N_PLAYERS-1:0]     RESULT,
  output logic                       DONE,
  output logic [2:0]                 DBG_STATE
);

  localparam int          NH         = N_PLAYERS + 1;
  localparam logic [2:0]  DEALER_IDX = 3'(N_PLAYERS);
  localparam logic [2:0]  LAST_P     = 3'(N_PLAYERS - 1);
  localparam logic [3:0]  MAXC       = 4'(MAX_CARDS);
  localparam logic [4:0]  STAND_SC   = 5'(DEALER_STAND);
  localparam logic [4:0]  BJ21       = 5'd21;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DEAL   = 3'd1,
    S_PLAY   = 3'd2,
    S_DEALER = 3'd3,
    S_SETTLE = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t state_q, state_d;

  // Per-hand state; entries above the dealer index are never targeted.
  logic [4:0] score_q [8];
  logic [3:0] soft_q  [8];
  logic [3:0] cnt_q   [8];

  logic [2:0]             active_q, active_d;
  logic                   deal_round_q, deal_round_d;
  logic                   hit_pend_q, hit_pend_d;
  logic [2*N_PLAYERS-1:0] result_q, result_d;

  logic       need, take, clear_all;
  logic [4:0] cur_score, dealer_score;
  logic [3:0] cur_soft, cur_cnt, dealer_soft, dealer_cnt;
  logic       all_bust, dealer_hit, card_ace;
  logic [5:0] sum_raw;
  logic [4:0] new_score;
  logic [3:0] new_soft;

  assign cur_score    = score_q[active_q];
  assign cur_soft     = soft_q[active_q];
  assign cur_cnt      = cnt_q[active_q];
  assign dealer_score = score_q[DEALER_IDX];
  assign dealer_soft  = soft_q[DEALER_IDX];
  assign dealer_cnt   = cnt_q[DEALER_IDX];

  // Card handshake: the source holds CARD valid while CARD_RDY=1; a card is
  // consumed only in a cycle where we request one and CARD_RDY=1, and that
  // same cycle pulses CARD_USED and LD_VALID together. No request, no pulse.
  assign take = need & CARD_RDY;

  always_comb begin
    card_ace  = (CARD == 4'd1);
    sum_raw   = {1'b0, cur_score} + (card_ace ? 6'd11 : {2'b00, CARD});
    new_soft  = cur_soft + {3'b000, card_ace};
    new_score = sum_raw[4:0];
    if ((sum_raw > 6'd21) && (new_soft != 4'd0)) begin
      new_score = sum_raw[4:0] - 5'd10;
      new_soft  = new_soft - 4'd1;
    end
  end

  always_comb begin
    all_bust = 1'b1;
    for (int p = 0; p < N_PLAYERS; p++) begin
      if (score_q[p] <= BJ21) all_bust = 1'b0;
    end
  end

`ifdef BJ_DEALER_H17_EN
  assign dealer_hit = ((dealer_score < STAND_SC) ||
                       ((dealer_score == STAND_SC) && (dealer_soft != 4'd0))) &&
                      (dealer_cnt < MAXC);
`else
  assign dealer_hit = (dealer_score < STAND_SC) && (dealer_cnt < MAXC);
`endif

  always_comb begin
    state_d      = state_q;
    active_d     = active_q;
    deal_round_d = deal_round_q;
    hit_pend_d   = hit_pend_q;
    result_d     = result_q;
    need         = 1'b0;
    clear_all    = 1'b0;
    if (EN) begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (START) begin
            state_d      = S_DEAL;
            clear_all    = 1'b1;
            active_d     = 3'd0;
            deal_round_d = 1'b0;
            hit_pend_d   = 1'b0;
            result_d     = '0;
          end
        end
        S_DEAL: begin
          need = 1'b1;
          if (CARD_RDY) begin
            if (active_q == DEALER_IDX) begin
              active_d = 3'd0;
              if (deal_round_q) state_d = S_PLAY;
              else              deal_round_d = 1'b1;
            end else begin
              active_d = active_q + 3'd1;
            end
          end
        end
        S_PLAY: begin
          // Turn ends on STAND, or automatically at 21, bust or a full hand.
          if (STAND || (cur_score >= BJ21) || (cur_cnt >= MAXC)) begin
            hit_pend_d = 1'b0;
            if (active_q == LAST_P) begin
              state_d  = S_DEALER;
              active_d = DEALER_IDX;
            end else begin
              active_d = active_q + 3'd1;
            end
          end else if (hit_pend_q || HIT) begin
            need       = 1'b1;
            hit_pend_d = ~CARD_RDY;
          end
        end
        S_DEALER: begin
          if (all_bust || !dealer_hit) state_d = S_SETTLE;
          else                         need    = 1'b1;
        end
        S_SETTLE: begin
          for (int p = 0; p < N_PLAYERS; p++) begin
            if (score_q[p] > BJ21)              result_d[2*p +: 2] = 2'b10;
            else if (dealer_score > BJ21)       result_d[2*p +: 2] = 2'b01;
            else if (score_q[p] > dealer_score) result_d[2*p +: 2] = 2'b01;
            else if (score_q[p] < dealer_score) result_d[2*p +: 2] = 2'b10;
            else                                result_d[2*p +: 2] = 2'b11;
          end
          state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      active_q     <= 3'd0;
      deal_round_q <= 1'b0;
      hit_pend_q   <= 1'b0;
      result_q     <= '0;
      for (int i = 0; i < 8; i++) begin
        score_q[i] <= 5'd0;
        soft_q[i]  <= 4'd0;
        cnt_q[i]   <= 4'd0;
      end
    end else if (EN) begin
      state_q      <= state_d;
      active_q     <= active_d;
      deal_round_q <= deal_round_d;
      hit_pend_q   <= hit_pend_d;
      result_q     <= result_d;
      for (int i = 0; i < 8; i++) begin
        if (clear_all) begin
          score_q[i] <= 5'd0;
          soft_q[i]  <= 4'd0;
          cnt_q[i]   <= 4'd0;
        end else if (take && (active_q == 3'(i))) begin
          score_q[i] <= new_score;
          soft_q[i]  <= new_soft;
          cnt_q[i]   <= cnt_q[i] + 4'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < NH; g++) begin : g_score
    assign SCORE[5*g +: 5] = score_q[g];
  end

  assign CARD_USED = take;
  assign LD_VALID  = take;
  assign LD_HAND   = active_q;
  assign LD_POS    = cur_cnt[2:0];
  assign LD_CARD   = CARD;
  assign ACTIVE    = active_q;
  assign RESULT    = result_q;
  assign DONE      = (state_q == S_DONE);
  assign DBG_STATE = state_q;

endmodule
